// File: rtl/uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler
//
// Purpose:
//   Shares a single uart_tx transmitter among NUM_REQ byte requesters. A
//   round-robin arbiter picks the next requester while idle. The FSM then
//   latches the winner's byte and sequences the transmitter handshake
//   (d_in, tx_send, enable_tx). It follows the frame through the
//   transmitter's sending status and enforces an idle gap of GAP_TICKS baud
//   ticks between frames. A free-running generator produces the baud_uart
//   tick from a programmable divisor.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   synchronous, active-low reset
//   req        in   [NUM_REQ-1:0]   per-requester transmit request (level)
//   req_data   in   [8*NUM_REQ-1:0] requester i byte at [8i+7:8i]
//   ack        out  [NUM_REQ-1:0]   one-cycle pulse: requester's byte latched
//   grant_id   out  [2:0]  index of the current / last granted requester
//   busy       out  high whenever the FSM is not in IDLE
//   err        out  one-cycle pulse when the transmitter never starts
//   baud_div   in   [15:0] baud tick period minus 1, in clocks
//   baud_uart  out  one-cycle baud tick to the transmitter
//   d_in       out  [7:0]  byte presented to the transmitter
//   tx_send    out  start request to the transmitter
//   enable_tx  out  transmitter enable, active-low (0 = enabled)
//   sending    in   transmitter frame-in-progress status
//   fsm_state  out  [2:0]  current FSM state encoding (debug visibility)
//
// Handshake semantics (single description for the whole block):
//   A requester raises req and holds req_data stable. While the FSM is
//   idle, the arbiter picks one requester. Two clocks after the request is
//   seen in IDLE, that requester receives exactly one ack pulse. The ack
//   cycle is the last cycle in which req_data must be valid. From the next
//   cycle on, the requester may change the data or drop req. Towards the
//   transmitter, tx_send is held high until sending is observed high (the
//   frame has started). The frame is then considered complete when sending
//   returns low.
//
// State encoding on fsm_state:
//   0 = IDLE, 1 = GRANT, 2 = START, 3 = WAIT_DONE, 4 = GAP
// -----------------------------------------------------------------------------
module uart_tx_scheduler #(
  parameter int NUM_REQ       = 4,
  parameter int GAP_TICKS     = 2,
  parameter int START_TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic [2:0]           grant_id,
  output logic                 busy,
  output logic                 err,
  input  logic [15:0]          baud_div,
  output logic                 baud_uart,
  output logic [7:0]           d_in,
  output logic                 tx_send,
  output logic                 enable_tx,
  input  logic                 sending,
  output logic [2:0]           fsm_state
);

  // Widths derived from the parameters.
  localparam int IW       = $clog2(NUM_REQ);
  localparam int TW       = $clog2(START_TIMEOUT + 1);
  localparam int GW       = (GAP_TICKS < 2) ? 1 : $clog2(GAP_TICKS);
  localparam int GAP_LAST = (GAP_TICKS > 0) ? GAP_TICKS - 1 : 0;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GRANT     = 3'd1,
    START     = 3'd2,
    WAIT_DONE = 3'd3,
    GAP       = 3'd4
  } state_t;

  state_t state;
  state_t state_nxt;

  // ---------------------------------------------------------------------------
  // Baud generator. It runs free and ignores the FSM. The comparison is
  // ">=" rather than "==". When baud_div drops below the running count,
  // the next edge therefore produces a tick instead of waiting for the
  // 16-bit counter to wrap.
  // ---------------------------------------------------------------------------
  logic [15:0] baud_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      baud_cnt  <= 16'd0;
      baud_uart <= 1'b0;
    end else if (baud_cnt >= baud_div) begin
      baud_cnt  <= 16'd0;
      baud_uart <= 1'b1;
    end else begin
      baud_cnt  <= baud_cnt + 16'd1;
      baud_uart <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin arbiter. The search starts one past the last winner and
  // wraps modulo NUM_REQ. The candidate index is one bit wider than the
  // pointer so that the wrap also works when NUM_REQ is not a power of two.
  // ---------------------------------------------------------------------------
  logic [IW-1:0] ptr;
  logic [IW-1:0] win;
  logic [IW-1:0] arb_win;
  logic          arb_found;
  logic [IW:0]   cand;

  always_comb begin
    arb_found = 1'b0;
    arb_win   = ptr;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(NUM_REQ)) begin
        cand = cand - (IW+1)'(NUM_REQ);
      end
      if (!arb_found && req[cand[IW-1:0]]) begin
        arb_found = 1'b1;
        arb_win   = cand[IW-1:0];
      end
    end
  end

  // Counters that qualify FSM transitions:
  //   tmo_cnt counts clocks spent in START waiting for sending to rise.
  //   gap_cnt counts baud ticks seen while in GAP.
  logic [TW-1:0] tmo_cnt;
  logic [GW-1:0] gap_cnt;

  // ---------------------------------------------------------------------------
  // FSM process 1: state register.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM process 2: next-state logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (arb_found) begin
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        state_nxt = START;
      end
      START: begin
        // A frame that starts takes priority over a timeout in the same cycle.
        if (sending) begin
          state_nxt = WAIT_DONE;
        end else if (tmo_cnt == TW'(START_TIMEOUT)) begin
          state_nxt = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!sending) begin
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (GAP_TICKS == 0) begin
          state_nxt = IDLE;
        end else if (baud_uart && (gap_cnt == GW'(GAP_LAST))) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM process 3: output logic. All transmitter-facing and requester-facing
  // outputs are registered, so this process computes their next values from
  // the current state and the chosen transition.
  // ---------------------------------------------------------------------------
  logic [NUM_REQ-1:0] ack_nxt;
  logic               err_nxt;
  logic               tx_send_nxt;
  logic               enable_tx_nxt;
  logic [7:0]         d_in_nxt;
  logic [2:0]         grant_nxt;

  always_comb begin
    ack_nxt       = '0;
    err_nxt       = 1'b0;
    tx_send_nxt   = 1'b0;
    enable_tx_nxt = enable_tx;
    d_in_nxt      = d_in;
    grant_nxt     = grant_id;
    case (state)
      IDLE: begin
        enable_tx_nxt = 1'b1;
      end
      GRANT: begin
        d_in_nxt      = req_data[{win, 3'b000} +: 8];
        grant_nxt     = 3'(win);
        ack_nxt       = NUM_REQ'(1) << win;
        enable_tx_nxt = 1'b0;
      end
      START: begin
        // tx_send is held only while still waiting. It drops when the
        // frame starts or when the start timeout gives up. A timeout also
        // releases the transmitter and flags the error.
        if (state_nxt == START) begin
          tx_send_nxt = 1'b1;
        end else if (state_nxt == IDLE) begin
          err_nxt       = 1'b1;
          enable_tx_nxt = 1'b1;
        end
      end
      WAIT_DONE: begin
        tx_send_nxt = 1'b0;
      end
      GAP: begin
        if (state_nxt == IDLE) begin
          enable_tx_nxt = 1'b1;
        end
      end
      default: begin
        enable_tx_nxt = 1'b1;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack       <= '0;
      err       <= 1'b0;
      tx_send   <= 1'b0;
      enable_tx <= 1'b1;
      d_in      <= 8'd0;
      grant_id  <= 3'd0;
    end else begin
      ack       <= ack_nxt;
      err       <= err_nxt;
      tx_send   <= tx_send_nxt;
      enable_tx <= enable_tx_nxt;
      d_in      <= d_in_nxt;
      grant_id  <= grant_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Arbitration pointer, registered winner, and transition counters.
  // The pointer resets to NUM_REQ-1 so that requester 0 is searched first.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr     <= IW'(NUM_REQ - 1);
      win     <= '0;
      tmo_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      if ((state == IDLE) && arb_found) begin
        ptr <= arb_win;
        win <= arb_win;
      end

      if (state == START) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end else begin
        tmo_cnt <= '0;
      end

      if (state != GAP) begin
        gap_cnt <= '0;
      end else if (baud_uart) begin
        gap_cnt <= gap_cnt + GW'(1);
      end
    end
  end

  assign busy      = (state != IDLE);
  assign fsm_state = state;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_scheduler
//
// Directed testbench for uart_tx_scheduler (NUM_REQ=4, GAP_TICKS=2,
// START_TIMEOUT=16). The bench itself plays the role of the transmitter: it
// drives sending in response to tx_send. Inputs are driven and outputs are
// sampled on the falling edge, half a period away from the active edge.
// -----------------------------------------------------------------------------
module tb_uart_tx_scheduler;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic [2:0]  grant_id;
  logic        busy;
  logic        err;
  logic [15:0] baud_div;
  logic        baud_uart;
  logic [7:0]  d_in;
  logic        tx_send;
  logic        enable_tx;
  logic        sending;
  logic [2:0]  fsm_state;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_scheduler #(
    .NUM_REQ       (4),
    .GAP_TICKS     (2),
    .START_TIMEOUT (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .grant_id  (grant_id),
    .busy      (busy),
    .err       (err),
    .baud_div  (baud_div),
    .baud_uart (baud_uart),
    .d_in      (d_in),
    .tx_send   (tx_send),
    .enable_tx (enable_tx),
    .sending   (sending),
    .fsm_state (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One active edge, then return at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    req     = 4'b0000;
    sending = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  // ---------------- driver tasks ----------------
  // Transmitter model: wait for tx_send, run a short frame, then wait for
  // the scheduler to go idle. ok=0 means a bounded wait expired.
  task automatic serve_frame(output bit ok);
    int i;
    ok = 1'b1;
    i  = 0;
    while (tx_send !== 1'b1 && i < 40) begin
      tick();
      i++;
    end
    if (tx_send !== 1'b1) ok = 1'b0;
    sending = 1'b1;
    repeat (3) tick();
    sending = 1'b0;
    i = 0;
    while (busy !== 1'b0 && i < 60) begin
      tick();
      i++;
    end
    if (busy !== 1'b0) ok = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n    = 1'b0;
    req      = 4'b0000;
    req_data = 32'h0;
    sending  = 1'b0;
    baud_div = 16'd0;
    @(negedge clk);
    repeat (3) tick();
    n_checks++;
    if (ack !== 4'b0000 || err !== 1'b0 || busy !== 1'b0 || tx_send !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_pulses: ack=%b err=%b busy=%b tx_send=%b, want 0000 0 0 0", ack, err, busy, tx_send);
    end
    n_checks++;
    if (enable_tx !== 1'b1 || d_in !== 8'h00 || grant_id !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_regs: enable_tx=%b d_in=%h grant_id=%0d, want 1 00 0", enable_tx, d_in, grant_id);
    end
    n_checks++;
    if (baud_uart !== 1'b0 || fsm_state !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_baud_fsm: baud_uart=%b fsm_state=%0d, want 0 0", baud_uart, fsm_state);
    end
    rst_n    = 1'b1;
    baud_div = 16'd3;
  endtask

  task automatic test_single();
    int i;
    req      = 4'b0100;
    req_data = 32'h0070_0000;
    tick();
    n_checks++;
    if (ack !== 4'b0000 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_grant_cycle: ack=%b busy=%b, want 0000 1", ack, busy);
    end
    tick();
    n_checks++;
    if (ack !== 4'b0100 || d_in !== 8'h70 || grant_id !== 3'd2 || enable_tx !== 1'b0 || tx_send !== 1'b0) begin
      n_fail++;
      $display("FAIL single_ack: ack=%b d_in=%h id=%0d en=%b send=%b, want 0100 70 2 0 0", ack, d_in, grant_id, enable_tx, tx_send);
    end
    req = 4'b0000;
    tick();
    n_checks++;
    if (tx_send !== 1'b1 || ack !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_tx_send_rise: tx_send=%b ack=%b, want 1 0000", tx_send, ack);
    end
    tick();
    n_checks++;
    if (tx_send !== 1'b1) begin
      n_fail++;
      $display("FAIL single_tx_send_hold: tx_send=%b, want 1", tx_send);
    end
    sending = 1'b1;
    tick();
    n_checks++;
    if (tx_send !== 1'b0 || fsm_state !== 3'd3 || d_in !== 8'h70) begin
      n_fail++;
      $display("FAIL single_wait_done: tx_send=%b state=%0d d_in=%h, want 0 3 70", tx_send, fsm_state, d_in);
    end
    tick();
    tick();
    // End the frame right after a baud tick, as a real transmitter would.
    i = 0;
    while (baud_uart !== 1'b1 && i < 20) begin
      tick();
      i++;
    end
    n_checks++;
    if (baud_uart !== 1'b1) begin
      n_fail++;
      $display("FAIL single_baud_seen: baud_uart=%b, want 1", baud_uart);
    end
    sending = 1'b0;
    tick();
    i = 0;
    while (busy === 1'b1 && i < 40) begin
      tick();
      i++;
    end
    n_checks++;
    if (i !== 8) begin
      n_fail++;
      $display("FAIL single_gap_len: gap clocks=%0d, want 8", i);
    end
    n_checks++;
    if (enable_tx !== 1'b1 || fsm_state !== 3'd0 || d_in !== 8'h70) begin
      n_fail++;
      $display("FAIL single_idle_after: en=%b state=%0d d_in=%h, want 1 0 70", enable_tx, fsm_state, d_in);
    end
  endtask

  task automatic test_round_robin();
    int         i;
    int         exp_id;
    logic [3:0] exp_ack;
    logic [7:0] exp_byte;
    bit         ok;
    do_reset();
    req      = 4'b1111;
    req_data = 32'hA3A2_A1A0;
    for (int g = 0; g < 5; g++) begin
      exp_id   = g % 4;
      exp_ack  = 4'b0001 << exp_id;
      exp_byte = 8'hA0 + 8'(exp_id);
      i = 0;
      while (ack === 4'b0000 && i < 40) begin
        tick();
        i++;
      end
      n_checks++;
      if (ack !== exp_ack || d_in !== exp_byte) begin
        n_fail++;
        $display("FAIL rr_grant%0d: ack=%b d_in=%h, want %b %h", g, ack, d_in, exp_ack, exp_byte);
      end
      if (g == 4) req = 4'b0000;
      serve_frame(ok);
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL rr_frame%0d: frame did not complete, ok=%0d want 1", g, ok);
      end
    end
  endtask

  task automatic test_timeout();
    int cnt;
    do_reset();
    req      = 4'b0001;
    req_data = 32'h0000_00C3;
    tick();
    tick();
    n_checks++;
    if (ack !== 4'b0001) begin
      n_fail++;
      $display("FAIL tmo_ack: ack=%b, want 0001", ack);
    end
    req = 4'b0000;
    tick();
    n_checks++;
    if (tx_send !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_tx_send_rise: tx_send=%b, want 1", tx_send);
    end
    cnt = 0;
    while (err !== 1'b1 && cnt < 40) begin
      tick();
      cnt++;
    end
    n_checks++;
    if (cnt !== 16) begin
      n_fail++;
      $display("FAIL tmo_err_delay: clocks=%0d, want 16", cnt);
    end
    n_checks++;
    if (tx_send !== 1'b0 || enable_tx !== 1'b1 || busy !== 1'b0 || fsm_state !== 3'd0) begin
      n_fail++;
      $display("FAIL tmo_release: send=%b en=%b busy=%b state=%0d, want 0 1 0 0", tx_send, enable_tx, busy, fsm_state);
    end
    tick();
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_err_pulse: err=%b, want 0", err);
    end
  endtask

  task automatic test_baud();
    int   bad;
    logic exp_b;
    baud_div = 16'd0;
    tick();
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      if (baud_uart !== 1'b1) bad++;
      tick();
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL baud_div0: missing ticks=%0d, want 0", bad);
    end
    // Counter is 0 here; div=4 gives ticks on the 5th, 10th, 15th edge.
    baud_div = 16'd4;
    bad = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      exp_b = ((k % 5) == 4);
      if (baud_uart !== exp_b) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL baud_div4: wrong cycles=%0d, want 0", bad);
    end
    baud_div = 16'd0;
    tick();
    tick();
    baud_div = 16'd9;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (baud_uart !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL baud_div9_count: early ticks=%0d, want 0", bad);
    end
    baud_div = 16'd2;
    tick();
    n_checks++;
    if (baud_uart !== 1'b1) begin
      n_fail++;
      $display("FAIL baud_div_drop: baud_uart=%b, want 1", baud_uart);
    end
    tick();
    exp_b = baud_uart;
    tick();
    n_checks++;
    if (exp_b !== 1'b0 || baud_uart !== 1'b0) begin
      n_fail++;
      $display("FAIL baud_div2_quiet: ticks=%b%b, want 00", exp_b, baud_uart);
    end
    tick();
    n_checks++;
    if (baud_uart !== 1'b1) begin
      n_fail++;
      $display("FAIL baud_div2_period: baud_uart=%b, want 1", baud_uart);
    end
    baud_div = 16'd3;
  endtask

  task automatic test_reset_mid_frame();
    int bad;
    req      = 4'b0010;
    req_data = 32'h0000_5C00;
    tick();
    tick();
    n_checks++;
    if (ack !== 4'b0010 || d_in !== 8'h5C) begin
      n_fail++;
      $display("FAIL midrst_ack: ack=%b d_in=%h, want 0010 5c", ack, d_in);
    end
    req = 4'b0000;
    tick();
    sending = 1'b1;
    tick();
    n_checks++;
    if (fsm_state !== 3'd3) begin
      n_fail++;
      $display("FAIL midrst_in_wait: state=%0d, want 3", fsm_state);
    end
    rst_n = 1'b0;
    tick();
    n_checks++;
    if (tx_send !== 1'b0 || enable_tx !== 1'b1 || busy !== 1'b0 || d_in !== 8'h00 || ack !== 4'b0000 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_outputs: send=%b en=%b busy=%b d_in=%h ack=%b err=%b, want 0 1 0 00 0000 0", tx_send, enable_tx, busy, d_in, ack, err);
    end
    sending = 1'b0;
    tick();
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      if (ack !== 4'b0000 || err !== 1'b0 || busy !== 1'b0) bad++;
      tick();
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL midrst_quiet: stray cycles=%0d, want 0", bad);
    end
  endtask

  task automatic test_late_request();
    int i;
    int bad;
    bit ok;
    do_reset();
    req      = 4'b0010;
    req_data = 32'h3300_1100;
    tick();
    tick();
    n_checks++;
    if (ack !== 4'b0010 || d_in !== 8'h11) begin
      n_fail++;
      $display("FAIL late_first_ack: ack=%b d_in=%h, want 0010 11", ack, d_in);
    end
    req = 4'b0000;
    tick();
    sending = 1'b1;
    tick();
    req = 4'b1000;
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (ack !== 4'b0000) bad++;
    end
    i = 0;
    while (baud_uart !== 1'b1 && i < 20) begin
      tick();
      i++;
    end
    n_checks++;
    if (baud_uart !== 1'b1) begin
      n_fail++;
      $display("FAIL late_baud_seen: baud_uart=%b, want 1", baud_uart);
    end
    sending = 1'b0;
    tick();
    i = 0;
    while (busy === 1'b1 && i < 40) begin
      if (ack !== 4'b0000) bad++;
      tick();
      i++;
    end
    n_checks++;
    if (i !== 8 || bad !== 0) begin
      n_fail++;
      $display("FAIL late_gap: gap=%0d early acks=%0d, want 8 0", i, bad);
    end
    n_checks++;
    if (ack !== 4'b0000 || fsm_state !== 3'd0) begin
      n_fail++;
      $display("FAIL late_idle: ack=%b state=%0d, want 0000 0", ack, fsm_state);
    end
    tick();
    n_checks++;
    if (ack !== 4'b0000 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL late_grant_cycle: ack=%b busy=%b, want 0000 1", ack, busy);
    end
    tick();
    n_checks++;
    if (ack !== 4'b1000 || d_in !== 8'h33 || grant_id !== 3'd3) begin
      n_fail++;
      $display("FAIL late_ack3: ack=%b d_in=%h id=%0d, want 1000 33 3", ack, d_in, grant_id);
    end
    req = 4'b0000;
    serve_frame(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL late_frame: frame did not complete, ok=%0d want 1", ok);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_baud();
    test_reset_mid_frame();
    test_late_request();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares one uart_tx transmitter among NUM_REQ byte requesters using round-robin arbitration.
- Sequences the transmitter's d_in, tx_send and enable_tx handshake, using its sending status to track each frame.
- Generates the baud_uart tick from a programmable divisor.
- Enforces an inter-frame gap and flags transmitters that never start.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- GAP_TICKS, 2, baud ticks of idle line between frames (0 = no gap).
- START_TIMEOUT, 1024, clocks allowed for sending to rise after tx_send asserts.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low
- req  in  NUM_REQ  per-requester transmit request, level
- req_data  in  8*NUM_REQ  requester i byte at [8i+7:8i]
- ack  out  NUM_REQ  one-cycle pulse; requester's byte latched
- grant_id  out  3  index of the currently or last granted requester
- busy  out  1  high in any state other than IDLE
- err  out  1  one-cycle pulse on start timeout
- baud_div  in  16  baud tick period minus 1, in clocks
- baud_uart  out  1  one-cycle baud tick to transmitter
- d_in  out  8  byte to transmitter
- tx_send  out  1  start request to transmitter
- enable_tx  out  1  transmitter enable, active-low (0 = enabled)
- sending  in  1  transmitter frame-in-progress status

Behaviour:
- Reset values: ack=0, grant_id=0, busy=0, err=0, baud_uart=0, d_in=0, tx_send=0, enable_tx=1. Round-robin pointer=NUM_REQ-1, so requester 0 wins first. Baud counter=0, FSM=IDLE.
- Reset mid-operation: all of the above take effect on the next edge; the in-flight frame is abandoned and no ack or err is issued.
- Baud generator:
  - 16-bit counter increments every clock.
  - When counter >= baud_div, baud_uart=1 for that cycle and the counter clears.
  - baud_div=0 gives a tick every clock.
  - A baud_div decrease below the current count produces a tick on the next cycle.
  - The generator runs continuously and is independent of FSM state.
- Arbitration:
  - Evaluated only in IDLE.
  - Search starts at pointer+1 and wraps modulo NUM_REQ; the first set req bit wins.
  - Pointer updates to the winner.
  - req changes outside IDLE are ignored.
  - A requester that keeps req high is served again only after every other active requester has been served once.
- FSM states: IDLE, GRANT, START, WAIT_DONE, GAP.
  - IDLE: enable_tx=1, tx_send=0. If any req is set, go to GRANT next cycle with the winner registered.
  - GRANT (1 cycle): d_in <= winner's byte, grant_id <= winner, ack[winner]=1, enable_tx <= 0. Go to START.
  - START: tx_send=1, timeout counter runs.
    - If sending=1, go to WAIT_DONE.
    - If the counter reaches START_TIMEOUT with sending still 0, pulse err, set enable_tx=1 and tx_send=0, and go to IDLE. The byte is dropped.
  - WAIT_DONE: tx_send=0, d_in held. When sending falls to 0, go to GAP.
  - GAP: enable_tx stays 0.
    - Count GAP_TICKS baud_uart pulses, then go to IDLE.
    - With GAP_TICKS=0, go to IDLE on the next cycle.
- Latency: req high in IDLE gives ack 2 clocks later and tx_send 3 clocks later.
- The ack pulse is the only acknowledgement. The requester may change req_data or drop req on the cycle after ack.
- busy=1 from GRANT through GAP inclusive.
- d_in keeps its last value in IDLE; it does not clear.
- Only one ack bit is ever high at a time.

Test Plan:
- Reset/single request:
  - Stimulus: rst_n=0 for 3 clocks; then req=4'b0100, data2=8'h70, baud_div=3, GAP_TICKS=2.
  - Required: ack=4'b0100 at +2 clocks, d_in=8'h70, tx_send high until sending rises.
  - Required: after sending falls, 8 clocks of GAP, then busy=0.
- Round-robin fairness: req=4'b1111 held, data i=8'hA0+i → ack order 0,1,2,3,0, with d_in 8'hA0,A1,A2,A3,A0.
- Timeout: sending tied 0, START_TIMEOUT=16, req=4'b0001 → err pulse 16 clocks after tx_send rises, then tx_send=0, enable_tx=1, busy=0, FSM in IDLE.
- Baud generator:
  - baud_div=0 gives a tick every clock; baud_div=4 gives a tick every 5 clocks.
  - Changing baud_div from 9 to 2 while the count is 6 gives a tick on the next cycle.
- Reset mid-frame: assert rst_n=0 during WAIT_DONE → next edge gives tx_send=0, enable_tx=1, busy=0, d_in=0, and no ack/err pulses.
- Late request: req[3] rises during WAIT_DONE of requester 1 → it is served only after GAP completes, with ack[3] 2 clocks after IDLE.
